dma_seq_demux: RTL and testbench

- Consumer end of the arbiter multiplexing sequence. Takes {last, vfid, len} entries from the MMU arbiter's mux output and steers the single shared DMA read-data AXI4-Stream to the N_REGIONS per-vFPGA streams.
- Each entry owns exactly len+1 beats of the shared stream; beats are routed in entry order.
- Sits between the host/card DMA read channel and the per-region user data interfaces.

---
 rtl/dma_seq_demux_pkg.sv | 23 ++
 rtl/dma_seq_demux_slice.sv | 44 ++++
 rtl/dma_seq_demux.sv | 175 +++++++++++++++++
 tb/tb_dma_seq_demux.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_seq_demux_pkg.sv
// Shared types for the DMA arbiter sequence path.
// Holds the {last, vfid, len} sequence entry and the demux FSM states.
package lynxTypes;

    localparam int N_REGIONS      = 4;
    localparam int N_REGIONS_BITS = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;
    localparam int LEN_BITS       = 28;
    localparam int AXI_DATA_BITS  = 512;
    localparam int BEAT_LOG_BITS  = $clog2(AXI_DATA_BITS / 8);
    localparam int BLEN_BITS      = LEN_BITS - BEAT_LOG_BITS;

    typedef struct packed {
        logic                      last;
        logic [N_REGIONS_BITS-1:0] vfid;
        logic [BLEN_BITS-1:0]      len;
    } mux_seq_t;

    typedef enum logic {
        ST_IDLE,
        ST_STREAM
    } dma_demux_state_t;

endpackage

// File: rtl/dma_seq_demux_slice.sv
// Two-entry AXIS skid register for one demux output region.
// Input ready comes from a flop, so it never depends on the output ready.
module dma_demux_slice #(
    parameter int W = 8
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data
);

    logic         main_vld;
    logic         skid_vld;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;

    assign s_ready = ~skid_vld;
    assign m_valid = main_vld;
    assign m_data  = main_q;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (!main_vld || m_ready) begin
            if (skid_vld) begin
                main_q   <= skid_q;
                main_vld <= 1'b1;
                skid_vld <= 1'b0;
            end else begin
                main_q   <= s_data;
                main_vld <= s_valid;
            end
        end else if (s_valid && s_ready) begin
            skid_q   <= s_data;
            skid_vld <= 1'b1;
        end
    end

endmodule

// File: rtl/dma_seq_demux.sv
// Steers the shared DMA read stream to per-region streams in sequence order.
// DMA_DEMUX_OREG_EN adds a skid register slice on every region output.
module dma_seq_demux #(
    parameter int DATA_BITS = lynxTypes::AXI_DATA_BITS,
    parameter int N_REGIONS = lynxTypes::N_REGIONS,
    parameter int LEN_BITS  = lynxTypes::LEN_BITS,
    localparam int BEAT_LOG_BITS  = $clog2(DATA_BITS / 8),
    localparam int N_REGIONS_BITS = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1,
    localparam int BLEN_BITS      = LEN_BITS - BEAT_LOG_BITS,
    localparam int SEQ_BITS       = 1 + N_REGIONS_BITS + BLEN_BITS
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   s_mux_valid,
    output logic                   s_mux_ready,
    input  logic [SEQ_BITS-1:0]    s_mux_data,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [DATA_BITS-1:0]   s_axis_tdata,
    input  logic [DATA_BITS/8-1:0] s_axis_tkeep,
    input  logic                   s_axis_tlast,
    output logic [N_REGIONS-1:0]   m_axis_tvalid,
    input  logic [N_REGIONS-1:0]   m_axis_tready,
    output logic [DATA_BITS-1:0]   m_axis_tdata,
    output logic [DATA_BITS/8-1:0] m_axis_tkeep,
    output logic [N_REGIONS-1:0]   m_axis_tlast
);

    import lynxTypes::*;

    dma_demux_state_t          state_q, state_d;
    logic [BLEN_BITS-1:0]      cnt_q, cnt_d;
    logic [N_REGIONS_BITS-1:0] vfid_q, vfid_d;
    logic                      last_q, last_d;

    logic                      seq_last;
    logic [N_REGIONS_BITS-1:0] seq_vfid;
    logic [BLEN_BITS-1:0]      seq_len;

    logic [N_REGIONS-1:0] sel_oh;
    logic [N_REGIONS-1:0] dst_valid;
    logic [N_REGIONS-1:0] dst_ready;
    logic                 others_busy;
    logic                 sel_hit;
    logic                 sel_ready;
    logic                 streaming;
    logic                 cnt_zero;
    logic                 beat_hs;
    logic                 final_hs;
    logic                 entry_hs;

    // Routing uses the sequence entry only; the DMA-side last is informational.
    logic unused_tlast;
    assign unused_tlast = s_axis_tlast;

    assign {seq_last, seq_vfid, seq_len} = s_mux_data;

    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < N_REGIONS; i++)
            sel_oh[i] = (int'(vfid_q) == i);
    end

    assign sel_hit   = |sel_oh;
    assign streaming = aresetn && (state_q == ST_STREAM);
    assign cnt_zero  = (cnt_q == '0);

    // Unmapped vfid drains its beats so the shared stream cannot deadlock.
    assign sel_ready = sel_hit ? ((|(sel_oh & dst_ready)) && !others_busy)
                               : 1'b1;

    assign s_axis_tready = streaming && sel_ready;
    assign beat_hs       = s_axis_tvalid && s_axis_tready;
    assign final_hs      = beat_hs && cnt_zero;
    assign s_mux_ready   = aresetn && ((state_q == ST_IDLE) || final_hs);
    assign entry_hs      = s_mux_valid && s_mux_ready;
    assign dst_valid     = (streaming && s_axis_tvalid) ? sel_oh : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vfid_d  = vfid_q;
        last_d  = last_q;
        unique case (state_q)
            ST_IDLE: begin
                if (entry_hs) begin
                    state_d = ST_STREAM;
                    cnt_d   = seq_len;
                    vfid_d  = seq_vfid;
                    last_d  = seq_last;
                end
            end
            ST_STREAM: begin
                if (beat_hs) begin
                    if (!cnt_zero) begin
                        cnt_d = cnt_q - BLEN_BITS'(1);
                    end else if (entry_hs) begin
                        cnt_d  = seq_len;
                        vfid_d = seq_vfid;
                        last_d = seq_last;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            vfid_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vfid_q  <= vfid_d;
            last_q  <= last_d;
        end
    end

`ifdef DMA_DEMUX_OREG_EN
    localparam int KEEP_BITS = DATA_BITS / 8;
    localparam int PW        = 1 + KEEP_BITS + DATA_BITS;

    logic [PW-1:0]        slice_in;
    logic [PW-1:0]        out_data [N_REGIONS];
    logic [N_REGIONS-1:0] out_valid;

    assign slice_in = {last_q && cnt_zero, s_axis_tkeep, s_axis_tdata};

    // Output data is shared, so only one slice may hold beats at a time.
    assign others_busy = |(~sel_oh & out_valid);

    for (genvar g = 0; g < N_REGIONS; g++) begin : g_slice
        dma_demux_slice #(
            .W(PW)
        ) u_slice (
            .aclk    (aclk),
            .aresetn (aresetn),
            .s_valid (dst_valid[g]),
            .s_ready (dst_ready[g]),
            .s_data  (slice_in),
            .m_valid (out_valid[g]),
            .m_ready (m_axis_tready[g]),
            .m_data  (out_data[g])
        );
    end

    always_comb begin
        m_axis_tvalid = '0;
        m_axis_tlast  = '0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        for (int i = 0; i < N_REGIONS; i++) begin
            if (aresetn && out_valid[i]) begin
                m_axis_tvalid[i] = 1'b1;
                m_axis_tlast[i]  = out_data[i][PW-1];
                m_axis_tdata     = out_data[i][DATA_BITS-1:0];
                m_axis_tkeep     = out_data[i][DATA_BITS +: KEEP_BITS];
            end
        end
    end
`else
    assign others_busy   = 1'b0;
    assign dst_ready     = m_axis_tready;
    assign m_axis_tvalid = dst_valid;
    assign m_axis_tlast  = (streaming && last_q && cnt_zero) ? sel_oh : '0;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tkeep  = s_axis_tkeep;
`endif

endmodule

// File: tb/tb_dma_seq_demux.sv
// Directed bench for dma_seq_demux: routing, back-to-back entries,
// backpressure, empty sequence stall and mid-burst reset.
module tb_dma_seq_demux;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic         s_mux_valid;
    logic         s_mux_ready;
    logic [24:0]  s_mux_data;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [511:0] s_axis_tdata;
    logic [63:0]  s_axis_tkeep;
    logic         s_axis_tlast;
    logic [3:0]   m_axis_tvalid;
    logic [3:0]   m_axis_tready;
    logic [511:0] m_axis_tdata;
    logic [63:0]  m_axis_tkeep;
    logic [3:0]   m_axis_tlast;

    int vectors = 0;
    int miscompares = 0;

    always #5 aclk = ~aclk;

    dma_seq_demux dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_mux_valid   (s_mux_valid),
        .s_mux_ready   (s_mux_ready),
        .s_mux_data    (s_mux_data),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge aclk);
        #1;
    endtask

    task automatic smp;
        @(negedge aclk);
    endtask

    function automatic logic [24:0] ent(input bit l, input int v, input int n);
        return {l, 2'(v), 22'(n)};
    endfunction

    function automatic logic [63:0] d64(input int k);
        return 64'hA5A5_0000_0000_0000 + 64'(k);
    endfunction

    task automatic put(input int k);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {448'h0, d64(k)};
    endtask

    initial begin
        int k;
        aresetn       = 1'b0;
        s_mux_valid   = 1'b0;
        s_mux_data    = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '1;
        s_axis_tlast  = 1'b0;
        m_axis_tready = '1;

        step;
        step;
        smp;
        chk("rst_mux_ready", 64'(s_mux_ready), 64'd0);
        chk("rst_tready", 64'(s_axis_tready), 64'd0);
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
        aresetn = 1'b1;
        step;
        smp;
        chk("idle_mux_ready", 64'(s_mux_ready), 64'd1);
        chk("idle_tready", 64'(s_axis_tready), 64'd0);
        step;

        // single entry to region 2, four beats
        s_mux_valid = 1'b1;
        s_mux_data  = ent(1, 2, 3);
        smp;
        chk("t1_accept", 64'(s_mux_ready), 64'd1);
        step;
        s_mux_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put(i);
            smp;
            chk("t1_vld", 64'(m_axis_tvalid), 64'h4);
            chk("t1_last", 64'(m_axis_tlast), (i == 3) ? 64'h4 : 64'h0);
            chk("t1_data", m_axis_tdata[63:0], d64(i));
            chk("t1_keep", m_axis_tkeep, 64'hFFFF_FFFF_FFFF_FFFF);
            step;
        end
        s_axis_tvalid = 1'b0;
        smp;
        chk("t1_idle", 64'(s_mux_ready), 64'd1);
        chk("t1_quiet", 64'(m_axis_tvalid), 64'd0);
        step;

        // back-to-back entries, no bubble
        s_mux_valid = 1'b1;
        s_mux_data  = ent(1, 0, 1);
        smp;
        step;
        s_mux_data = ent(1, 3, 0);
        put(10);
        smp;
        chk("t2_vld0", 64'(m_axis_tvalid), 64'h1);
        chk("t2_last0", 64'(m_axis_tlast), 64'h0);
        chk("t2_mrdy0", 64'(s_mux_ready), 64'd0);
        step;
        put(11);
        smp;
        chk("t2_vld1", 64'(m_axis_tvalid), 64'h1);
        chk("t2_last1", 64'(m_axis_tlast), 64'h1);
        chk("t2_mrdy1", 64'(s_mux_ready), 64'd1);
        chk("t2_data1", m_axis_tdata[63:0], d64(11));
        step;
        s_mux_valid = 1'b0;
        put(12);
        smp;
        chk("t2_vld2", 64'(m_axis_tvalid), 64'h8);
        chk("t2_last2", 64'(m_axis_tlast), 64'h8);
        chk("t2_data2", m_axis_tdata[63:0], d64(12));
        step;
        s_axis_tvalid = 1'b0;
        smp;
        chk("t2_idle", 64'(s_mux_ready), 64'd1);
        step;

        // non-final entry: tlast never raised
        s_mux_valid = 1'b1;
        s_mux_data  = ent(0, 1, 2);
        smp;
        step;
        s_mux_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            put(15 + i);
            smp;
            chk("t3_vld", 64'(m_axis_tvalid), 64'h2);
            chk("t3_last", 64'(m_axis_tlast), 64'h0);
            step;
        end
        s_axis_tvalid = 1'b0;
        smp;
        chk("t3_idle", 64'(s_mux_ready), 64'd1);
        step;

        // region 1 ready toggling
        s_mux_valid = 1'b1;
        s_mux_data  = ent(1, 1, 3);
        smp;
        step;
        s_mux_valid = 1'b0;
        k = 0;
        for (int c = 0; c < 7; c++) begin
            m_axis_tready = (c % 2 == 0) ? 4'hF : 4'hD;
            put(20 + k);
            smp;
            chk("t4_rdy", 64'(s_axis_tready), (c % 2 == 0) ? 64'd1 : 64'd0);
            chk("t4_vld", 64'(m_axis_tvalid), 64'h2);
            chk("t4_data", m_axis_tdata[63:0], d64(20 + k));
            chk("t4_last", 64'(m_axis_tlast), (k == 3) ? 64'h2 : 64'h0);
            if (c % 2 == 0)
                k++;
            step;
        end
        m_axis_tready = 4'hF;
        s_axis_tvalid = 1'b0;
        smp;
        chk("t4_done", 64'(s_mux_ready), 64'd1);
        step;

        // data before any entry is stalled
        put(30);
        for (int c = 0; c < 10; c++) begin
            smp;
            chk("t5_stall", 64'(s_axis_tready), 64'd0);
            chk("t5_quiet", 64'(m_axis_tvalid), 64'd0);
            step;
        end
        s_mux_valid = 1'b1;
        s_mux_data  = ent(1, 0, 0);
        smp;
        chk("t5_acc_rdy", 64'(s_axis_tready), 64'd0);
        chk("t5_acc_mux", 64'(s_mux_ready), 64'd1);
        step;
        s_mux_valid = 1'b0;
        smp;
        chk("t5_vld", 64'(m_axis_tvalid), 64'h1);
        chk("t5_last", 64'(m_axis_tlast), 64'h1);
        chk("t5_data", m_axis_tdata[63:0], d64(30));
        chk("t5_rdy", 64'(s_axis_tready), 64'd1);
        step;
        s_axis_tvalid = 1'b0;

        // reset in the middle of a six-beat entry
        s_mux_valid = 1'b1;
        s_mux_data  = ent(1, 2, 5);
        smp;
        step;
        s_mux_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            put(40 + i);
            smp;
            chk("t6_vld", 64'(m_axis_tvalid), 64'h4);
            step;
        end
        aresetn     = 1'b0;
        s_mux_valid = 1'b1;
        s_mux_data  = ent(1, 1, 0);
        put(42);
        smp;
        chk("t6_rst_vld", 64'(m_axis_tvalid), 64'h0);
        chk("t6_rst_mux", 64'(s_mux_ready), 64'd0);
        chk("t6_rst_rdy", 64'(s_axis_tready), 64'd0);
        step;
        step;
        aresetn       = 1'b1;
        s_mux_valid   = 1'b0;
        s_axis_tvalid = 1'b0;
        smp;
        chk("t6_idle", 64'(s_mux_ready), 64'd1);
        chk("t6_quiet", 64'(m_axis_tvalid), 64'h0);
        step;
        s_mux_valid = 1'b1;
        s_mux_data  = ent(1, 0, 0);
        smp;
        step;
        s_mux_valid = 1'b0;
        put(50);
        smp;
        chk("t6_vld", 64'(m_axis_tvalid), 64'h1);
        chk("t6_last", 64'(m_axis_tlast), 64'h1);
        chk("t6_data", m_axis_tdata[63:0], d64(50));
        step;
        s_axis_tvalid = 1'b0;
        smp;
        chk("t6_done", 64'(s_mux_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors,
                 miscompares);
        $finish;
    end

endmodule
